// File: rtl/seg_capture32.sv
// Recovers the 32-bit value shown on a scanned 8-digit seven-segment display.
// Optional build macro: SEG_DP_CHECK_EN (a settled digit with its dp lit is rejected).
module seg_capture32 #(
   parameter int unsigned SETTLE = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  digit_anode,
   input  logic [7:0]  segment,
   output logic [31:0] disp_num,
   output logic        frame_valid,
   output logic        seg_err,
   output logic [7:0]  digit_mask
);

   localparam logic [7:0] SettleMax  = 8'(SETTLE);
   localparam logic [7:0] SettleLast = 8'(SETTLE - 1);

   logic [7:0]  s_an_q, s_seg_q, p_an_q, p_seg_q;
   logic [7:0]  stab_cnt_q, stab_cnt_d;
   logic [31:0] shadow_q, shadow_d;
   logic [31:0] disp_num_q, disp_num_d;
   logic [7:0]  digit_mask_q, digit_mask_d;
   logic        frame_valid_q, frame_valid_d;
   logic        seg_err_q, seg_err_d;

   logic        same;
   logic        an_ok;
   logic [3:0]  zero_cnt;
   logic [2:0]  dig_idx;
   logic [3:0]  nib;
   logic        pat_ok;
   logic        commit;
   logic [7:0]  mask_set;

   // Double sampling: s_* is the current view, p_* the previous one for change detection.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s_an_q  <= '0;
         s_seg_q <= '0;
         p_an_q  <= '0;
         p_seg_q <= '0;
      end else begin
         s_an_q  <= digit_anode;
         s_seg_q <= segment;
         p_an_q  <= s_an_q;
         p_seg_q <= s_seg_q;
      end
   end

   // Exactly one active-low anode must be asserted for a legal digit select.
   always_comb begin
      zero_cnt = '0;
      dig_idx  = '0;
      for (int i = 0; i < 8; i++) begin
         if (!s_an_q[i]) begin
            zero_cnt = zero_cnt + 4'd1;
            dig_idx  = 3'(i);
         end
      end
      an_ok = (zero_cnt == 4'd1);
   end

   assign same = (s_an_q == p_an_q) && (s_seg_q == p_seg_q);

   always_comb begin
      stab_cnt_d = '0;
      if (same && an_ok) begin
         stab_cnt_d = (stab_cnt_q == SettleMax) ? stab_cnt_q : stab_cnt_q + 8'd1;
      end
   end

   // One commit per dwell: the counter saturates past the strobe value until a change.
   assign commit = same && an_ok && (stab_cnt_q == SettleLast);

   always_comb begin
      nib    = 4'h0;
      pat_ok = 1'b1;
      case (s_seg_q[6:0])
         7'h40:   nib = 4'h0;
         7'h79:   nib = 4'h1;
         7'h24:   nib = 4'h2;
         7'h30:   nib = 4'h3;
         7'h19:   nib = 4'h4;
         7'h12:   nib = 4'h5;
         7'h02:   nib = 4'h6;
         7'h78:   nib = 4'h7;
         7'h00:   nib = 4'h8;
         7'h10:   nib = 4'h9;
         7'h08:   nib = 4'hA;
         7'h03:   nib = 4'hB;
         7'h46:   nib = 4'hC;
         7'h21:   nib = 4'hD;
         7'h06:   nib = 4'hE;
         7'h0E:   nib = 4'hF;
         default: pat_ok = 1'b0;
      endcase
`ifdef SEG_DP_CHECK_EN
      if (!s_seg_q[7]) begin
         pat_ok = 1'b0;
      end
`else
`endif
   end

   assign mask_set = digit_mask_q | (8'b1 << dig_idx);

   always_comb begin
      shadow_d      = shadow_q;
      disp_num_d    = disp_num_q;
      digit_mask_d  = digit_mask_q;
      frame_valid_d = 1'b0;
      seg_err_d     = 1'b0;
      if (commit) begin
         if (pat_ok) begin
            shadow_d[{dig_idx, 2'b00} +: 4] = nib;
            if (mask_set == 8'hFF) begin
               // Frame closes on this edge, so publish the shadow with this nibble merged.
               disp_num_d    = shadow_d;
               frame_valid_d = 1'b1;
               digit_mask_d  = '0;
            end else begin
               digit_mask_d = mask_set;
            end
         end else begin
            seg_err_d             = 1'b1;
            digit_mask_d[dig_idx] = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stab_cnt_q    <= '0;
         shadow_q      <= '0;
         disp_num_q    <= '0;
         digit_mask_q  <= '0;
         frame_valid_q <= 1'b0;
         seg_err_q     <= 1'b0;
      end else begin
         stab_cnt_q    <= stab_cnt_d;
         shadow_q      <= shadow_d;
         disp_num_q    <= disp_num_d;
         digit_mask_q  <= digit_mask_d;
         frame_valid_q <= frame_valid_d;
         seg_err_q     <= seg_err_d;
      end
   end

   assign disp_num    = disp_num_q;
   assign frame_valid = frame_valid_q;
   assign seg_err     = seg_err_q;
   assign digit_mask  = digit_mask_q;

endmodule
